// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory behind a request/ready handshake.
// Adds programmable wait states and flags illegal requests on err.
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] dir,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic        ready,
    output logic        err,
    output logic        busy,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] LIMIT = 33'(4 * DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    state_t state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          op_rd_q, op_rd_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   din_q, din_d;
    logic          pend_q, pend_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic [31:0]   dout_q, dout_d;
    logic [15:0]   rd_count_q, rd_count_d;
    logic [15:0]   wr_count_q, wr_count_d;

    logic          acc;
    logic          acc_rd;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_data;
    logic          illegal;

    logic [31:0] mem [DEPTH];

    assign illegal = (MemRead & MemWrite) | (dir[1:0] != 2'b00)
                   | ({1'b0, dir} >= LIMIT);

    // Next-state, access strobe and registered-output values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_rd_d  = op_rd_q;
        idx_d    = idx_q;
        din_d    = din_q;
        pend_d   = pend_q;
        acc      = 1'b0;
        acc_rd   = 1'b0;
        acc_idx  = idx_q;
        acc_data = din_q;
        unique case (state_q)
            IDLE: begin
                if (MemRead | MemWrite) begin
                    op_rd_d = MemRead;
                    idx_d   = dir[AW+1:2];
                    din_d   = dataIn;
                    if (illegal) begin
                        pend_d  = 1'b1;
                        state_d = ACK;
                    end else begin
                        pend_d = 1'b0;
                        if (LATENCY == 0) begin
                            // Zero wait states: access on the capture edge,
                            // straight from the inputs being latched.
                            acc      = 1'b1;
                            acc_rd   = MemRead;
                            acc_idx  = dir[AW+1:2];
                            acc_data = dataIn;
                            state_d  = ACK;
                        end else begin
                            cnt_d   = 4'(LATENCY);
                            state_d = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    acc     = 1'b1;
                    acc_rd  = op_rd_q;
                    state_d = ACK;
                end
            end
            ACK: begin
                pend_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ready_d    = (state_d == ACK);
        err_d      = (state_d == ACK) & pend_d;
        busy_d     = (state_d != IDLE);
        dout_d     = dout_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (acc && acc_rd) begin
            dout_d = mem[acc_idx];
            if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
        end
        if (acc && !acc_rd) begin
            if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
        end
    end

    // Control state and outputs; in-flight work is dropped on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_rd_q    <= 1'b0;
            idx_q      <= '0;
            din_q      <= '0;
            pend_q     <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            dout_q     <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_rd_q    <= op_rd_d;
            idx_q      <= idx_d;
            din_q      <= din_d;
            pend_q     <= pend_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            dout_q     <= dout_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Storage array; deliberately not reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (acc && !acc_rd) mem[acc_idx] <= acc_data;
    end

    assign dataOut  = dout_q;
    assign ready    = ready_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random requests against two responders
// (2 and 0 wait states) compared with a transaction-level memory model.
module tb_dmem_responder;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        mr [2];
    logic        mw [2];
    logic [31:0] a  [2];
    logic [31:0] d  [2];
    logic [31:0] dout [2];
    logic        rdy [2];
    logic        er  [2];
    logic        bsy [2];
    logic [15:0] rc  [2];
    logic [15:0] wc  [2];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .MemRead(mr[0]), .MemWrite(mw[0]),
        .dir(a[0]), .dataIn(d[0]), .dataOut(dout[0]), .ready(rdy[0]),
        .err(er[0]), .busy(bsy[0]), .rd_count(rc[0]), .wr_count(wc[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .MemRead(mr[1]), .MemWrite(mw[1]),
        .dir(a[1]), .dataIn(d[1]), .dataOut(dout[1]), .ready(rdy[1]),
        .err(er[1]), .busy(bsy[1]), .rd_count(rc[1]), .wr_count(wc[1])
    );

    // Reference model: one word array per responder plus counters.
    logic [31:0] mmem   [2][DEPTH];
    bit          mknown [2][DEPTH];
    logic [31:0] mdout  [2];
    bit          mdk    [2];
    logic [15:0] mrc    [2];
    logic [15:0] mwc    [2];
    int          lat    [2];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            mrc[s]   = '0;
            mwc[s]   = '0;
            mdout[s] = '0;
            mdk[s]   = 1'b1;
        end
    endtask

    task automatic chk_quiet(input int s, input string tag);
        chk({tag, ".ready"}, 32'(rdy[s]), 0);
        chk({tag, ".err"},   32'(er[s]),  0);
        chk({tag, ".busy"},  32'(bsy[s]), 0);
        chk({tag, ".rd_count"}, 32'(rc[s]), 32'(mrc[s]));
        chk({tag, ".wr_count"}, 32'(wc[s]), 32'(mwc[s]));
        if (mdk[s]) chk({tag, ".dataOut"}, dout[s], mdout[s]);
    endtask

    function automatic bit is_legal(input bit rd, input bit wr,
                                    input logic [31:0] addr);
        return !(rd && wr) && (addr % 4 == 0) && (addr < 4 * DEPTH);
    endfunction

    // Apply the effect of one completed request to the model.
    task automatic model_access(input int s, input bit rd,
                                input logic [31:0] addr,
                                input logic [31:0] data);
        int w;
        w = int'(addr / 4);
        if (rd) begin
            mdk[s]   = mknown[s][w];
            mdout[s] = mmem[s][w];
            if (mrc[s] != 16'hFFFF) mrc[s]++;
        end else begin
            mmem[s][w]   = data;
            mknown[s][w] = 1'b1;
            if (mwc[s] != 16'hFFFF) mwc[s]++;
        end
    endtask

    // One request issued at a negedge; returns at the negedge of the
    // IDLE cycle after the response.
    task automatic xact(input int s, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input bit scramble, input string tag);
        bit legal;
        int exp_cyc;
        legal   = is_legal(rd, wr, addr);
        exp_cyc = legal ? lat[s] + 1 : 1;
        mr[s] = rd;
        mw[s] = wr;
        a[s]  = addr;
        d[s]  = data;
        if (legal) model_access(s, rd, addr, data);
        for (int k = 1; k <= exp_cyc; k++) begin
            @(negedge clk);
            chk({tag, ".ready"}, 32'(rdy[s]), 32'(k == exp_cyc));
            chk({tag, ".busy"},  32'(bsy[s]), 1);
            if (k == exp_cyc) begin
                chk({tag, ".err"}, 32'(er[s]), 32'(!legal));
                chk({tag, ".rd_count"}, 32'(rc[s]), 32'(mrc[s]));
                chk({tag, ".wr_count"}, 32'(wc[s]), 32'(mwc[s]));
                if (mdk[s]) chk({tag, ".dataOut"}, dout[s], mdout[s]);
                mr[s] = 1'b0;
                mw[s] = 1'b0;
            end else if (scramble) begin
                a[s] = $urandom;
                d[s] = $urandom;
            end
        end
        @(negedge clk);
        chk_quiet(s, {tag, ".after"});
    endtask

    initial begin
        logic [31:0] addr;
        logic [31:0] data;
        bit rd, wr;
        int r;

        lat[0] = 2;
        lat[1] = 0;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            mr[s] = 1'b0;
            mw[s] = 1'b0;
            a[s]  = '0;
            d[s]  = '0;
            for (int w = 0; w < DEPTH; w++) mknown[s][w] = 1'b0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        chk_quiet(0, "reset0");
        chk_quiet(1, "reset1");
        rst = 1'b0;
        @(negedge clk);

        xact(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, "store_l2");
        xact(0, 1, 0, 32'h10, 32'h0, 0, "load_l2");
        xact(1, 0, 1, 32'h10, 32'hDEADBEEF, 0, "store_l0");
        xact(1, 1, 0, 32'h10, 32'h0, 0, "load_l0");

        xact(0, 1, 0, 32'h12, 32'h0, 0, "misalign");
        xact(0, 1, 0, 32'h10, 32'h0, 0, "reload1");
        xact(0, 1, 0, 32'(4 * DEPTH), 32'h0, 0, "range");
        xact(0, 1, 0, 32'h10, 32'h0, 0, "reload2");
        xact(0, 1, 1, 32'h10, 32'h11111111, 0, "both");
        xact(0, 1, 0, 32'h10, 32'h0, 0, "reload3");
        xact(1, 0, 1, 32'h12, 32'h22222222, 0, "misalign_l0");
        xact(1, 1, 0, 32'h10, 32'h0, 0, "reload_l0");

        // Request held across several completions: captures at the end
        // of cycles 0, 4 and 8, responses in cycles 3, 7 and 11.
        mr[0] = 1'b1;
        a[0]  = 32'h10;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("held.ready", 32'(rdy[0]),
                32'(k == 3 || k == 7 || k == 11));
            chk("held.busy", 32'(bsy[0]),
                32'(!(k == 4 || k == 8 || k == 12)));
            if (k == 3 || k == 7 || k == 11) model_access(0, 1, 32'h10, 0);
            if (k == 9 || k == 11) begin
                chk("held.rd_count", 32'(rc[0]), 32'(mrc[0]));
                chk("held.dataOut", dout[0], mdout[0]);
            end
            if (k == 10) mr[0] = 1'b0;
        end

        // Reset while a store is waiting: the store must be discarded.
        mw[0] = 1'b1;
        a[0]  = 32'h10;
        d[0]  = 32'h12345678;
        @(negedge clk);
        chk("midrst.busy_before", 32'(bsy[0]), 1);
        rst = 1'b1;
        #1;
        model_reset();
        chk_quiet(0, "midrst0");
        chk_quiet(1, "midrst1");
        mw[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_quiet(0, "postrst");
        xact(0, 1, 0, 32'h10, 32'h0, 0, "postrst_load");

        // Random mix of legal and illegal requests on both responders.
        for (int i = 0; i < 80; i++) begin
            r  = $urandom_range(0, 9);
            rd = 1'($urandom_range(0, 1));
            wr = !rd;
            data = $urandom;
            addr = 32'($urandom_range(0, 15) * 4);
            if (r == 0) addr = addr | 32'($urandom_range(1, 3));
            if (r == 1) addr = 32'(4 * DEPTH) + 32'($urandom_range(0, 4000));
            if (r == 2) begin
                rd = 1'b1;
                wr = 1'b1;
            end
            xact(i % 2, rd, wr, addr, data, 1'($urandom_range(0, 1)),
                 "rand");
        end

        // Saturation of the load counter.
        @(negedge clk);
        force dut.rd_count_q = 16'hFFFE;
        #1;
        release dut.rd_count_q;
        mrc[0] = 16'hFFFE;
        @(negedge clk);
        for (int i = 0; i < 3; i++) xact(0, 1, 0, 32'h10, 32'h0, 0, "sat");
        chk("sat.final", 32'(rc[0]), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
